// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared coin codes, nickel values, sequencer states and change decode
package vend_pkg;

  typedef enum logic [1:0] {
    COIN_REJ = 2'b00,
    COIN_N   = 2'b01,
    COIN_D   = 2'b10,
    COIN_Q   = 2'b11
  } coin_t;

  localparam int unsigned NK_N = 1;
  localparam int unsigned NK_D = 2;
  localparam int unsigned NK_Q = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_VEND,
    ST_CHANGE,
    ST_REFUND,
    ST_CLEAR
  } state_t;

  // Change owed by the core: X + 2*Y + 3*Z nickels (max 6).
  function automatic logic [2:0] change_nk(input logic x, input logic y, input logic z);
    return {2'b00, x} + {1'b0, y, 1'b0} + {1'b0, z, z};
  endfunction

  function automatic logic [2:0] coin_nk(input logic [1:0] c);
    case (c)
      COIN_N:  return 3'(NK_N);
      COIN_D:  return 3'(NK_D);
      COIN_Q:  return 3'(NK_Q);
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_coin_fifo.sv
// rtl/vend_coin_fifo.sv - small synchronous FIFO buffering coin events ahead of the core
module vend_coin_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic         w_do_push;
  logic         w_do_pop;

  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign o_empty = (r_wr == r_rd);
  assign o_full  = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign o_data  = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_do_pop)  r_rd <= r_rd + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/vend_txn_controller.sv
// rtl/vend_txn_controller.sv - sequences buffered coins into the vending core and runs
// dispense, change and refund handshakes.
module vend_txn_controller
  import vend_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int CREDIT_W    = 4,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  output logic                coin_ready,
  input  logic                cancel,
  output logic                core_n,
  output logic                core_d,
  output logic                core_q,
  output logic                core_clr,
  input  logic                core_w,
  input  logic                core_x,
  input  logic                core_y,
  input  logic                core_z,
  output logic                vend_req,
  input  logic                vend_ack,
  output logic                nk_req,
  input  logic                nk_ack,
  output logic [CREDIT_W-1:0] credit_nk,
  output logic                busy
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]       TMAX = TW'(TIMEOUT_CYC - 1);
  localparam logic [CREDIT_W-1:0] CMAX = '1;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_coin;
  logic [CREDIT_W-1:0] r_credit;
  logic [2:0]          r_chg;
  logic [TW-1:0]       r_timer;
  logic                r_cancel_pend;
  logic                r_core_clr;

  logic                w_push;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [1:0]          w_fifo_data;
  logic                w_feed_coin;
  logic [CREDIT_W:0]   w_sum;
  logic [CREDIT_W-1:0] w_credit_add;

  vend_coin_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (2)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (coin_type),
    .i_pop   (w_pop),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign coin_ready = ~w_full & ~r_cancel_pend &
                      (r_state != ST_REFUND) & (r_state != ST_CLEAR);
  assign w_push     = coin_valid & coin_ready;

  assign w_feed_coin = (r_state == ST_FEED) && (r_coin != COIN_REJ);
  assign core_n      = (r_state == ST_FEED) && (r_coin == COIN_N) && !r_core_clr;
  assign core_d      = (r_state == ST_FEED) && (r_coin == COIN_D) && !r_core_clr;
  assign core_q      = (r_state == ST_FEED) && (r_coin == COIN_Q) && !r_core_clr;
  assign core_clr    = r_core_clr;
  assign vend_req    = (r_state == ST_VEND);
  assign nk_req      = (r_state == ST_CHANGE) || (r_state == ST_REFUND);
  assign credit_nk   = r_credit;
  assign busy        = (r_state != ST_IDLE);

  assign w_sum        = {1'b0, r_credit} + (CREDIT_W+1)'(coin_nk(r_coin));
  assign w_credit_add = (w_sum > {1'b0, CMAX}) ? CMAX : w_sum[CREDIT_W-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Buffered coins drain before a pending cancel is honoured.
        if (r_cancel_pend && w_empty) begin
          w_next = (r_credit != '0) ? ST_REFUND : ST_CLEAR;
        end else if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = ST_FEED;
        end else if ((r_timer == TMAX) && (r_credit != '0)) begin
          w_next = ST_REFUND;
        end
      end
      ST_FEED:   w_next = (w_feed_coin && core_w) ? ST_VEND : ST_IDLE;
      ST_VEND: begin
        if (vend_ack) w_next = (r_chg != 3'd0) ? ST_CHANGE : ST_IDLE;
      end
      ST_CHANGE: begin
        if (nk_ack && (r_chg <= 3'd1)) w_next = ST_IDLE;
      end
      ST_REFUND: begin
        if (nk_ack && (r_credit <= CREDIT_W'(1))) w_next = ST_CLEAR;
      end
      ST_CLEAR:  w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_coin        <= 2'b00;
      r_credit      <= '0;
      r_chg         <= 3'd0;
      r_timer       <= '0;
      r_cancel_pend <= 1'b0;
      r_core_clr    <= 1'b0;
    end else begin
      if (w_pop) r_coin <= w_fifo_data;

      // A vend consumes all credit; the core reports any overpayment as change.
      if (w_feed_coin) begin
        if (core_w) begin
          r_credit <= '0;
          r_chg    <= change_nk(core_x, core_y, core_z);
        end else begin
          r_credit <= w_credit_add;
        end
      end else if ((r_state == ST_REFUND) && nk_ack && (r_credit != '0)) begin
        r_credit <= r_credit - CREDIT_W'(1);
      end

      if ((r_state == ST_CHANGE) && nk_ack && (r_chg != 3'd0)) r_chg <= r_chg - 3'd1;

      if (w_push || (r_credit == '0) || (r_state != ST_IDLE) || (w_next != ST_IDLE)) begin
        r_timer <= '0;
      end else if (r_timer != TMAX) begin
        r_timer <= r_timer + TW'(1);
      end

      if (cancel)                    r_cancel_pend <= 1'b1;
      else if (r_state == ST_CLEAR)  r_cancel_pend <= 1'b0;

      r_core_clr <= (w_next == ST_CLEAR);
    end
  end

endmodule

// File: tb/tb_vend_txn_controller.sv
// tb/tb_vend_txn_controller.sv - table-driven and sequence checks of the vending transaction
// controller with a feed-pulse scoreboard.
module tb_vend_txn_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       coin_ready;
  logic       cancel;
  logic       core_n, core_d, core_q, core_clr;
  logic       core_w, core_x, core_y, core_z;
  logic       vend_req, nk_req;
  logic       vend_ack = 1'b0;
  logic       nk_ack   = 1'b0;
  logic [3:0] credit_nk;
  logic       busy;

  logic cfg_w, cfg_x, cfg_y, cfg_z;
  logic vend_ack_en, nk_ack_en;

  int n_vec = 0;
  int n_err = 0;
  int vend_cnt = 0;
  int nk_cnt = 0;
  int clr_cnt = 0;
  int feed_cnt = 0;
  logic [2:0] exp_q[$];

  typedef struct {
    logic [1:0] coin;
    logic       w, x, y, z;
    int         credit;
    int         vends;
    int         nks;
  } vec_t;

  vec_t tbl[8];

  always #5 clk = ~clk;

  // Core stand-in: vend/change strobes answer only a quarter pulse.
  assign core_w = core_q & cfg_w;
  assign core_x = core_q & cfg_x;
  assign core_y = core_q & cfg_y;
  assign core_z = core_q & cfg_z;

  vend_txn_controller #(
    .FIFO_DEPTH  (4),
    .CREDIT_W    (4),
    .TIMEOUT_CYC (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .coin_valid (coin_valid),
    .coin_type  (coin_type),
    .coin_ready (coin_ready),
    .cancel     (cancel),
    .core_n     (core_n),
    .core_d     (core_d),
    .core_q     (core_q),
    .core_clr   (core_clr),
    .core_w     (core_w),
    .core_x     (core_x),
    .core_y     (core_y),
    .core_z     (core_z),
    .vend_req   (vend_req),
    .vend_ack   (vend_ack),
    .nk_req     (nk_req),
    .nk_ack     (nk_ack),
    .credit_nk  (credit_nk),
    .busy       (busy)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [2:0] e;
    vend_ack = vend_req & vend_ack_en;
    nk_ack   = nk_req & nk_ack_en;
    if (!reset) begin
      if (vend_req && vend_ack) vend_cnt++;
      if (nk_req && nk_ack) nk_cnt++;
      if (core_clr) begin
        clr_cnt++;
        chk("clr_excl_pulse", {core_n, core_d, core_q}, 0);
      end
      if (core_n | core_d | core_q) begin
        feed_cnt++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL feed_unexpected: got %b expected no pulse", {core_n, core_d, core_q});
        end else begin
          e = exp_q.pop_front();
          chk("feed_pulse", {core_n, core_d, core_q}, e);
        end
      end
    end
  end

  task automatic push_coin(input logic [1:0] t);
    bit ok = 0;
    coin_valid = 1'b1;
    coin_type  = t;
    for (int k = 0; k < 50 && !ok; k++) begin
      if (coin_ready) ok = 1;
      tick();
    end
    coin_valid = 1'b0;
    if (!ok) begin
      n_vec++;
      n_err++;
      $display("FAIL push_stall: got coin_ready=0 expected 1");
    end else if (t != 2'b00) begin
      exp_q.push_back(t == 2'b01 ? 3'b100 : (t == 2'b10 ? 3'b010 : 3'b001));
    end
  endtask

  task automatic wait_idle();
    int quiet = 0;
    for (int k = 0; k < 200 && quiet < 3; k++) begin
      tick();
      if (busy) quiet = 0;
      else      quiet++;
    end
    if (quiet < 3) begin
      n_vec++;
      n_err++;
      $display("FAIL settle: got busy=%0d expected idle", busy);
    end
  endtask

  task automatic wait_nk_req(output bit seen);
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      if (nk_req) seen = 1;
      else        tick();
    end
    if (!seen) begin
      n_vec++;
      n_err++;
      $display("FAIL nk_req_wait: got nk_req=0 expected 1");
    end
  endtask

  initial begin
    int v0, k0, c0, f0, idle;
    bit seen;

    tbl[0] = '{coin: 2'b11, w: 1, x: 0, y: 0, z: 0, credit: 0, vends: 1, nks: 0};
    tbl[1] = '{coin: 2'b01, w: 0, x: 0, y: 0, z: 0, credit: 1, vends: 0, nks: 0};
    tbl[2] = '{coin: 2'b10, w: 0, x: 0, y: 0, z: 0, credit: 3, vends: 0, nks: 0};
    tbl[3] = '{coin: 2'b11, w: 1, x: 1, y: 1, z: 0, credit: 0, vends: 1, nks: 3};
    tbl[4] = '{coin: 2'b00, w: 1, x: 1, y: 1, z: 1, credit: 0, vends: 0, nks: 0};
    tbl[5] = '{coin: 2'b10, w: 0, x: 0, y: 0, z: 0, credit: 2, vends: 0, nks: 0};
    tbl[6] = '{coin: 2'b10, w: 0, x: 0, y: 0, z: 0, credit: 4, vends: 0, nks: 0};
    tbl[7] = '{coin: 2'b11, w: 1, x: 1, y: 0, z: 1, credit: 0, vends: 1, nks: 4};

    reset = 1'b1; coin_valid = 1'b0; coin_type = 2'b00; cancel = 1'b0;
    cfg_w = 0; cfg_x = 0; cfg_y = 0; cfg_z = 0;
    vend_ack_en = 1'b1; nk_ack_en = 1'b1;
    repeat (3) tick();

    chk("rst_coin_ready", coin_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_credit", credit_nk, 0);
    chk("rst_vend_req", vend_req, 0);
    chk("rst_nk_req", nk_req, 0);
    chk("rst_core_clr", core_clr, 0);
    chk("rst_core_pulse", {core_n, core_d, core_q}, 0);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 8; i++) begin
      cfg_w = tbl[i].w; cfg_x = tbl[i].x; cfg_y = tbl[i].y; cfg_z = tbl[i].z;
      v0 = vend_cnt; k0 = nk_cnt;
      push_coin(tbl[i].coin);
      wait_idle();
      chk($sformatf("vec%0d_credit", i), credit_nk, tbl[i].credit);
      chk($sformatf("vec%0d_vends", i), vend_cnt - v0, tbl[i].vends);
      chk($sformatf("vec%0d_nks", i), nk_cnt - k0, tbl[i].nks);
    end
    chk("sb_drained", exp_q.size(), 0);

    // Cancel with two nickels of credit: refund, then a single clear.
    cfg_w = 0; cfg_x = 0; cfg_y = 0; cfg_z = 0;
    k0 = nk_cnt; c0 = clr_cnt;
    push_coin(2'b01);
    push_coin(2'b01);
    cancel = 1'b1; tick(); cancel = 1'b0;
    chk("cancel_blocks_ready", coin_ready, 0);
    wait_idle();
    chk("cancel_refund_nks", nk_cnt - k0, 2);
    chk("cancel_clr_cycles", clr_cnt - c0, 1);
    chk("cancel_credit", credit_nk, 0);
    chk("cancel_ready_back", coin_ready, 1);

    // Cancel alongside the second queued coin: both coins feed before the refund.
    k0 = nk_cnt; c0 = clr_cnt; f0 = feed_cnt;
    push_coin(2'b10);
    cancel = 1'b1;
    push_coin(2'b10);
    cancel = 1'b0;
    chk("q_cancel_ready_low", coin_ready, 0);
    wait_nk_req(seen);
    if (seen) chk("q_cancel_feeds_first", feed_cnt - f0, 2);
    wait_idle();
    chk("q_cancel_refund_nks", nk_cnt - k0, 4);
    chk("q_cancel_clr", clr_cnt - c0, 1);

    // Cancel with no credit goes straight to clear.
    k0 = nk_cnt; c0 = clr_cnt;
    cancel = 1'b1; tick(); cancel = 1'b0;
    wait_idle();
    chk("zero_cancel_nks", nk_cnt - k0, 0);
    chk("zero_cancel_clr", clr_cnt - c0, 1);

    // Inactivity timeout after a dime.
    k0 = nk_cnt; c0 = clr_cnt;
    push_coin(2'b10);
    for (int k = 0; k < 20 && credit_nk != 4'd2; k++) tick();
    chk("timeout_credit", credit_nk, 2);
    idle = 0;
    for (int k = 0; k < 40 && !nk_req; k++) begin
      if (!busy) idle++;
      tick();
    end
    chk("timeout_idle_cycles", idle, 8);
    wait_idle();
    chk("timeout_nks", nk_cnt - k0, 2);
    chk("timeout_clr", clr_cnt - c0, 1);
    chk("timeout_credit_end", credit_nk, 0);

    // Stall VEND, fill the FIFO, then reset in the middle of CHANGE.
    cfg_w = 1; cfg_x = 0; cfg_y = 1; cfg_z = 0;
    vend_ack_en = 1'b0;
    push_coin(2'b11);
    for (int i = 0; i < 4; i++) push_coin(2'b01);
    chk("fifo_full_ready", coin_ready, 0);
    chk("fifo_full_vend_req", vend_req, 1);
    vend_ack_en = 1'b1;
    wait_nk_req(seen);
    #1 reset = 1'b1;
    #1;
    chk("midrst_coin_ready", coin_ready, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_nk_req", nk_req, 0);
    chk("midrst_vend_req", vend_req, 0);
    chk("midrst_credit", credit_nk, 0);
    chk("midrst_core_clr", core_clr, 0);
    exp_q.delete();
    tick(); tick();
    reset = 1'b0;
    cfg_w = 0; cfg_y = 0;
    push_coin(2'b01);
    wait_idle();
    chk("post_rst_credit", credit_nk, 1);
    chk("post_rst_sb", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
